// File: rtl/keypad_entry_pkg.sv
// ============================================================================
// Module : keypad_entry_pkg
// Desc   : Shared key codes, scanner state encoding and helpers for the keypad
//          entry block.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package keypad_entry_pkg;

    localparam int BCD_W = 4;

    localparam logic [3:0] KEY_0    = 4'd0;
    localparam logic [3:0] KEY_1    = 4'd1;
    localparam logic [3:0] KEY_2    = 4'd2;
    localparam logic [3:0] KEY_3    = 4'd3;
    localparam logic [3:0] KEY_4    = 4'd4;
    localparam logic [3:0] KEY_5    = 4'd5;
    localparam logic [3:0] KEY_6    = 4'd6;
    localparam logic [3:0] KEY_7    = 4'd7;
    localparam logic [3:0] KEY_8    = 4'd8;
    localparam logic [3:0] KEY_9    = 4'd9;
    localparam logic [3:0] KEY_A    = 4'd10;
    localparam logic [3:0] KEY_B    = 4'd11;
    localparam logic [3:0] KEY_C    = 4'd12;
    localparam logic [3:0] KEY_D    = 4'd13;
    localparam logic [3:0] KEY_STAR = 4'd14;
    localparam logic [3:0] KEY_HASH = 4'd15;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } scan_state_t;

    // Active-low drive pattern for a row index.
    function automatic logic [3:0] row_drive(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

    // Lowest-index low column; meaningless when no column is low.
    function automatic logic [1:0] lowest_low(input logic [3:0] cols);
        if (!cols[0])      return 2'd0;
        else if (!cols[1]) return 2'd1;
        else if (!cols[2]) return 2'd2;
        else               return 2'd3;
    endfunction

    // Matrix layout: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D
    function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'h0: code = KEY_1;
            4'h1: code = KEY_2;
            4'h2: code = KEY_3;
            4'h3: code = KEY_A;
            4'h4: code = KEY_4;
            4'h5: code = KEY_5;
            4'h6: code = KEY_6;
            4'h7: code = KEY_B;
            4'h8: code = KEY_7;
            4'h9: code = KEY_8;
            4'hA: code = KEY_9;
            4'hB: code = KEY_C;
            4'hC: code = KEY_STAR;
            4'hD: code = KEY_0;
            4'hE: code = KEY_HASH;
            default: code = KEY_D;
        endcase
        return code;
    endfunction

    function automatic logic is_valid_time(input logic [15:0] t);
        logic ok;
        ok = (t[15:12] <= 4'd2) && (t[7:4] <= 4'd5);
        if (t[15:12] == 4'd2 && t[11:8] > 4'd3) ok = 1'b0;
        return ok;
    endfunction

endpackage

`default_nettype wire

// File: rtl/keypad_scanner.sv
// ============================================================================
// Module : keypad_scanner
// Desc   : Row scanning, column synchroniser and press/release debounce FSM.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_scanner
    import keypad_entry_pkg::*;
#(
    parameter int SCAN_DIV     = 16,
    parameter int DEBOUNCE_CNT = 256
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic       key_event,
    output logic [3:0] key_code
);

    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int DEB_W = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CNT - 1);

    logic [3:0]       col_meta;
    logic [3:0]       col_sync;
    logic [1:0]       row_idx;
    logic [1:0]       idx_p1;
    logic [1:0]       idx_p2;
    logic [DIV_W-1:0] div_cnt;
    logic [DEB_W-1:0] deb_cnt;
    logic [1:0]       key_row;
    logic [1:0]       key_col;
    scan_state_t      state;

    logic       any_low;
    logic [1:0] low_col;
    logic       sample_valid;

    // The row index travels alongside the column synchroniser so every
    // synchronised sample is tagged with the row that was driven when it was taken.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_meta <= 4'hF;
            col_sync <= 4'hF;
            idx_p1   <= 2'd0;
            idx_p2   <= 2'd0;
        end else begin
            col_meta <= col_in;
            col_sync <= col_meta;
            idx_p1   <= row_idx;
            idx_p2   <= idx_p1;
        end
    end

    always_comb begin
        any_low      = ~&col_sync;
        low_col      = lowest_low(col_sync);
        sample_valid = (idx_p2 == row_idx);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_SCAN;
            row_idx   <= 2'd0;
            row_out   <= 4'b1110;
            div_cnt   <= '0;
            deb_cnt   <= '0;
            key_row   <= 2'd0;
            key_col   <= 2'd0;
            key_event <= 1'b0;
            key_code  <= 4'd0;
        end else begin
            key_event <= 1'b0;
            case (state)
                ST_SCAN: begin
                    if (any_low) begin
                        key_row <= idx_p2;
                        key_col <= low_col;
                        row_idx <= idx_p2;
                        row_out <= row_drive(idx_p2);
                        deb_cnt <= DEB_W'(1);
                        div_cnt <= '0;
                        state   <= ST_DEBOUNCE;
                    end else if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        row_idx <= row_idx + 2'd1;
                        row_out <= row_drive(row_idx + 2'd1);
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                ST_DEBOUNCE: begin
                    // Samples still in flight from a later row are skipped.
                    if (sample_valid) begin
                        if (any_low && low_col == key_col) begin
                            if (deb_cnt >= DEB_LAST) begin
                                key_event <= 1'b1;
                                key_code  <= key_lookup(key_row, key_col);
                                state     <= ST_PRESSED;
                            end else begin
                                deb_cnt <= deb_cnt + 1'b1;
                            end
                        end else begin
                            div_cnt <= '0;
                            state   <= ST_SCAN;
                        end
                    end
                end
                ST_PRESSED: begin
                    deb_cnt <= '0;
                    state   <= ST_RELEASE;
                end
                default: begin
                    if (any_low) begin
                        deb_cnt <= '0;
                    end else if (deb_cnt >= DEB_LAST) begin
                        deb_cnt <= '0;
                        div_cnt <= '0;
                        state   <= ST_SCAN;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/keypad_entry.sv
// ============================================================================
// Module : keypad_entry
// Desc   : Keypad HH:MM entry register with validation and commit pulses.
//          Optional idle timeout enabled by defining KEYPAD_TIMEOUT_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_entry
    import keypad_entry_pkg::*;
#(
    parameter int SCAN_DIV       = 16,
    parameter int DEBOUNCE_CNT   = 256,
    parameter int TIMEOUT_CYCLES = 2**24
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  col_in,
    output logic [3:0]  row_out,
    output logic [15:0] keypad_time,
    output logic [2:0]  digit_count,
    output logic        alarm_load,
    output logic        time_load,
    output logic        entry_error
);

    logic       key_event;
    logic [3:0] key_code;
    logic       timeout_hit;

    keypad_scanner #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) u_scanner (
        .clk       (clk),
        .reset_n   (reset_n),
        .col_in    (col_in),
        .row_out   (row_out),
        .key_event (key_event),
        .key_code  (key_code)
    );

`ifdef KEYPAD_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    logic [IDLE_W-1:0] idle_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idle_cnt <= '0;
        end else if (key_event || digit_count == 3'd0 || idle_cnt == IDLE_LAST) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    assign timeout_hit = (digit_count != 3'd0) && (idle_cnt == IDLE_LAST);
`else
    logic [31:0] timeout_unused;
    assign timeout_unused = TIMEOUT_CYCLES;
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            keypad_time <= 16'h0000;
            digit_count <= 3'd0;
            alarm_load  <= 1'b0;
            time_load   <= 1'b0;
            entry_error <= 1'b0;
        end else begin
            alarm_load  <= 1'b0;
            time_load   <= 1'b0;
            entry_error <= 1'b0;
            // The committed value stays visible for the pulse cycle, then clears.
            if (alarm_load || time_load) begin
                keypad_time <= 16'h0000;
                digit_count <= 3'd0;
            end else if (key_event) begin
                if (key_code <= KEY_9) begin
                    if (digit_count < 3'd4) begin
                        keypad_time <= {keypad_time[15-BCD_W:0], key_code};
                        digit_count <= digit_count + 3'd1;
                    end
                end else begin
                    case (key_code)
                        KEY_HASH: begin
                            if (digit_count != 3'd0) begin
                                keypad_time <= {{BCD_W{1'b0}}, keypad_time[15:BCD_W]};
                                digit_count <= digit_count - 3'd1;
                            end
                        end
                        KEY_STAR: begin
                            keypad_time <= 16'h0000;
                            digit_count <= 3'd0;
                        end
                        KEY_A, KEY_B: begin
                            if (digit_count == 3'd4 && is_valid_time(keypad_time)) begin
                                alarm_load <= (key_code == KEY_A);
                                time_load  <= (key_code == KEY_B);
                            end else begin
                                entry_error <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end else if (timeout_hit) begin
                keypad_time <= 16'h0000;
                digit_count <= 3'd0;
            end
        end
    end

endmodule

`default_nettype wire
